// File: rtl/memc_arbiter_pkg.sv
// memc_arbiter_pkg: shared types and defaults for the SRAM memory controller.
//   memc_state_t : controller FSM states (IDLE/ACCESS/DONE)
//   memc_grant_t : arbitration grant (CPU port 0, display port 1)
//   MEMC_DATAWIDTH / MEMC_ADDRWIDTH : default bus widths
//   MEMC_CNT_W   : wait-state counter width (WAIT_STATES legal 0..7)
package memc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } memc_state_t;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_DISP = 1'b1
  } memc_grant_t;

  localparam int unsigned MEMC_DATAWIDTH = 16;
  localparam int unsigned MEMC_ADDRWIDTH = 16;
  localparam int unsigned MEMC_CNT_W     = 3;

endpackage

// File: rtl/memc_arb_sel.sv
// memc_arb_sel: grant select between CPU and display requesters.
// Build option: MEMC_ROUND_ROBIN_EN
//   defined   : on a tie the port not granted last wins (last_grant resets to
//               CPU, so the display wins the first tie)
//   undefined : fixed display priority
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   cpu_req   : decoded CPU request
//   disp_req  : display request
//   load      : a grant is being taken this cycle (updates last_grant)
//   grant     : selected port, combinational
module memc_arb_sel
  import memc_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        disp_req,
  input  logic        load,
  output memc_grant_t grant
);

`ifdef MEMC_ROUND_ROBIN_EN
  memc_grant_t last_grant;

  always_comb begin
    grant = GNT_CPU;
    if (cpu_req && disp_req) begin
      grant = (last_grant == GNT_CPU) ? GNT_DISP : GNT_CPU;
    end else if (disp_req) begin
      grant = GNT_DISP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_CPU;
    end else if (load) begin
      last_grant <= grant;
    end
  end
`else
  always_comb begin
    grant = disp_req ? GNT_DISP : GNT_CPU;
  end

  // Fixed priority needs neither history nor the CPU request.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, cpu_req, load};
`endif

endmodule

// File: rtl/memc_arbiter.sv
// memc_arbiter: arbitrates one asynchronous SRAM between the CPU (port 0) and
// the display/glyph fetch (port 1), generating SRAM pin timing with
// WAIT_STATES extra access cycles. Build option MEMC_ROUND_ROBIN_EN selects
// round-robin tie-breaking (see memc_arb_sel); default is display priority.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   cpu_ce_n/oe_n/we_n          : CPU SRAM strobes (active low), write wins
//   cpu_addr, cpu_din, cpu_dout : CPU address, write data, read data
//   cpu_stall                   : CPU must hold its request
//   disp_req, disp_addr         : display read request/address (held to ack)
//   disp_dout, disp_ack         : display read data, one-cycle ack pulse
//   sram_*                      : registered SRAM pins; sram_dq_oe drives dq
module memc_arbiter
  import memc_arbiter_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = MEMC_DATAWIDTH,
  parameter int unsigned ADDRWIDTH   = MEMC_ADDRWIDTH,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_ce_n,
  input  logic                 cpu_oe_n,
  input  logic                 cpu_we_n,
  input  logic [ADDRWIDTH-1:0] cpu_addr,
  input  logic [DATAWIDTH-1:0] cpu_din,
  output logic [DATAWIDTH-1:0] cpu_dout,
  output logic                 cpu_stall,
  input  logic                 disp_req,
  input  logic [ADDRWIDTH-1:0] disp_addr,
  output logic [DATAWIDTH-1:0] disp_dout,
  output logic                 disp_ack,
  output logic [ADDRWIDTH-1:0] sram_addr,
  input  logic [DATAWIDTH-1:0] sram_dq_in,
  output logic [DATAWIDTH-1:0] sram_dq_out,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  localparam logic [MEMC_CNT_W-1:0] WS = MEMC_CNT_W'(WAIT_STATES);

  memc_state_t           state;
  memc_grant_t           grant_q;
  memc_grant_t           sel_grant;
  logic                  wr_q;
  logic [MEMC_CNT_W-1:0] cnt;
  logic [MEMC_CNT_W-1:0] cnt_nxt;
  logic                  cpu_req;
  logic                  cpu_ack;
  logic                  arb_load;

  assign cpu_req   = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n);
  assign cpu_ack   = (state == ST_DONE) && (grant_q == GNT_CPU);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign arb_load  = (state == ST_IDLE) && (cpu_req || disp_req);
  assign cnt_nxt   = cnt + MEMC_CNT_W'(1);

  memc_arb_sel u_sel (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .disp_req (disp_req),
    .load     (arb_load),
    .grant    (sel_grant)
  );

  // Pins are registered so that each ACCESS cycle shows the strobe level
  // computed for it on the preceding edge; reset forces them inactive at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_q     <= GNT_CPU;
      wr_q        <= 1'b0;
      cnt         <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      cpu_dout    <= '0;
      disp_dout   <= '0;
      disp_ack    <= 1'b0;
    end else begin
      disp_ack <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_load) begin
            state     <= ST_ACCESS;
            cnt       <= '0;
            grant_q   <= sel_grant;
            sram_ce_n <= 1'b0;
            if (sel_grant == GNT_DISP) begin
              wr_q      <= 1'b0;
              sram_addr <= disp_addr;
              sram_oe_n <= 1'b0;
            end else begin
              wr_q        <= ~cpu_we_n;
              sram_addr   <= cpu_addr;
              sram_dq_out <= cpu_din;
              sram_dq_oe  <= ~cpu_we_n;
              sram_oe_n   <= ~cpu_we_n;
              // With no wait states the single ACCESS cycle is the hold cycle.
              sram_we_n   <= cpu_we_n | (WS == '0);
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt_nxt;
          if (cnt == WS) begin
            state      <= ST_DONE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            disp_ack   <= (grant_q == GNT_DISP);
            if (!wr_q) begin
              if (grant_q == GNT_DISP) disp_dout <= sram_dq_in;
              else                     cpu_dout  <= sram_dq_in;
            end
          end else if (wr_q) begin
            // we_n rises for the last ACCESS cycle to hold data past the strobe.
            sram_we_n <= (cnt_nxt >= WS);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memc_arbiter.sv
// Bench for memc_arbiter: table of single transfers plus hand-written
// sequences (contention, reset abort, zero wait states). Read data is
// scoreboarded: expected values are queued when a read is issued and
// compared when the port is acknowledged.
module tb_memc_arbiter;
  import memc_arbiter_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (WAIT_STATES = 2)
  logic          cpu_ce_n = 1'b1, cpu_oe_n = 1'b1, cpu_we_n = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_stall;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_dout;
  logic          disp_ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_in, sram_dq_out;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  memc_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_dout(disp_dout), .disp_ack(disp_ack),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // second DUT with no wait states, CPU port only
  logic          cpu_oe_n0 = 1'b1, cpu_ce_n0 = 1'b1;
  logic          cpu_we_n0 = 1'b1;
  logic [AW-1:0] cpu_addr0 = '0;
  logic [DW-1:0] cpu_din0 = '0;
  logic [DW-1:0] cpu_dout0;
  logic          cpu_stall0;
  logic          disp_req0 = 1'b0;
  logic [AW-1:0] disp_addr0 = '0;
  logic [DW-1:0] disp_dout0;
  logic          disp_ack0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_dq_in0, sram_dq_out0;
  logic          sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;

  memc_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .cpu_ce_n(cpu_ce_n0), .cpu_oe_n(cpu_oe_n0), .cpu_we_n(cpu_we_n0),
    .cpu_addr(cpu_addr0), .cpu_din(cpu_din0), .cpu_dout(cpu_dout0), .cpu_stall(cpu_stall0),
    .disp_req(disp_req0), .disp_addr(disp_addr0), .disp_dout(disp_dout0), .disp_ack(disp_ack0),
    .sram_addr(sram_addr0), .sram_dq_in(sram_dq_in0), .sram_dq_out(sram_dq_out0),
    .sram_dq_oe(sram_dq_oe0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0)
  );

  // SRAM models
  logic [DW-1:0] mem [0:65535];
  assign sram_dq_in  = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : '0;
  assign sram_dq_in0 = (!sram_ce_n0 && !sram_oe_n0) ? (16'h5A5A ^ sram_addr0) : '0;

  always @(posedge clk) begin
    if (rst) begin
      mem[16'h1234] <= 16'h00FF;
      mem[16'h0000] <= 16'hC0DE;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr] <= sram_dq_out;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] disp_q[$];

  always @(negedge clk) begin
    if (disp_ack) begin
      if (disp_q.size() == 0) check("disp_ack_unexpected", 32'd1, 32'd0);
      else                    check("disp_dout", disp_dout, disp_q.pop_front());
    end
    if (!cpu_ce_n && !cpu_oe_n && cpu_we_n && !cpu_stall) begin
      if (cpu_q.size() == 0) check("cpu_ack_unexpected", 32'd1, 32'd0);
      else                   check("cpu_dout", cpu_dout, cpu_q.pop_front());
    end
  end

  // One CPU transfer; cycle k=1 is the IDLE cycle in which it is sampled,
  // so release (DONE) lands at k = WS+3 and ACCESS spans k = 2..WS+2.
  task automatic cpu_xfer(input logic wr, input logic both, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    int k = 0, we_lo = 0, oe_lo = 0, st_acc = 0;
    logic done = 1'b0, pins_ok = 1'b1;
    @(posedge clk); #1;
    cpu_ce_n = 1'b0;
    cpu_we_n = ~wr;
    cpu_oe_n = (wr && !both) ? 1'b1 : 1'b0;
    cpu_addr = addr;
    cpu_din  = wr ? data : '0;
    if (!wr) cpu_q.push_back(data);
    while (!done && k < 40) begin
      @(negedge clk); k++;
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n) begin
        if (cpu_stall) st_acc++;
        if (sram_addr !== addr) pins_ok = 1'b0;
        if (wr && (sram_dq_out !== data || !sram_dq_oe)) pins_ok = 1'b0;
      end
      if (!cpu_stall) done = 1'b1;
    end
    check("cpu_done", done, 1);
    check("cpu_release_cycle", k, WS + 3);
    check("cpu_stall_access_cycles", st_acc, WS + 1);
    check("cpu_we_low_cycles", we_lo, wr ? WS : 0);
    check("cpu_oe_low_cycles", oe_lo, wr ? 0 : WS + 1);
    check("cpu_pins_stable", pins_ok, 1);
    @(posedge clk); #1;
    cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
  endtask

  task automatic disp_xfer(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    int k = 0, oe_lo = 0;
    logic done = 1'b0, pins_ok = 1'b1;
    @(posedge clk); #1;
    disp_req  = 1'b1;
    disp_addr = addr;
    disp_q.push_back(exp);
    while (!done && k < 40) begin
      @(negedge clk); k++;
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n && sram_addr !== addr) pins_ok = 1'b0;
      if (disp_ack) done = 1'b1;
    end
    check("disp_done", done, 1);
    check("disp_ack_cycle", k, WS + 3);
    check("disp_oe_low_cycles", oe_lo, WS + 1);
    check("disp_pins_stable", pins_ok, 1);
    @(posedge clk); #1;
    disp_req = 1'b0;
    @(negedge clk);
    check("disp_ack_one_cycle", disp_ack, 0);
  endtask

  typedef struct {
    logic          is_disp;
    logic          wr;
    logic          both;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[9];

  initial begin
    int k, dk, ck, ev, oe_lo, st_acc, ce_lo;
    logic saw_ack, saw_ce;
    logic rr_exp[4];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0040, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h00FF};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hA5A5};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hA5A5};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'hC0DE};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h1357};  // both strobes low: write
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h1357};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h1357};  // CPU last: next tie goes to display

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_addr_dq", {sram_addr, sram_dq_out}, 0);
    check("rst_douts", {cpu_dout, disp_dout}, 0);
    check("rst_ack_stall", {disp_ack, cpu_stall}, 0);
    check("rst_ce_n_ws0", sram_ce_n0, 1);
    rst = 1'b0;

    // zero wait states: one ACCESS cycle, release at k=3
    @(posedge clk); #1;
    cpu_ce_n0 = 1'b0; cpu_oe_n0 = 1'b0; cpu_addr0 = 16'h0007;
    k = 0; oe_lo = 0; st_acc = 0; ce_lo = 0;
    do begin
      @(negedge clk); k++;
      if (!sram_oe_n0) oe_lo++;
      if (!sram_ce_n0) begin
        ce_lo++;
        if (cpu_stall0) st_acc++;
      end
    end while (cpu_stall0 && k < 20);
    check("ws0_release_cycle", k, 3);
    check("ws0_access_cycles", ce_lo, 1);
    check("ws0_stall_access_cycles", st_acc, 1);
    check("ws0_oe_low_cycles", oe_lo, 1);
    check("ws0_cpu_dout", cpu_dout0, 16'h5A5D);
    @(posedge clk); #1;
    cpu_ce_n0 = 1'b1; cpu_oe_n0 = 1'b1;

    // table of single transfers
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_disp) disp_xfer(vecs[i].addr, vecs[i].data);
      else                 cpu_xfer(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].data);
    end

    // simultaneous requests: display first, CPU released at 2*(WS+3)
    @(posedge clk); #1;
    cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_addr = 16'h0040; cpu_q.push_back(16'hBEEF);
    disp_req = 1'b1; disp_addr = 16'h1234; disp_q.push_back(16'h00FF);
    k = 0; dk = 0; ck = 0;
    while ((dk == 0 || ck == 0) && k < 60) begin
      @(negedge clk); k++;
      if (disp_ack && dk == 0) begin
        dk = k;
        disp_req = 1'b0;
      end
      if (!cpu_stall && ck == 0) ck = k;
    end
    check("tie_disp_ack_cycle", dk, WS + 3);
    check("tie_cpu_release_cycle", ck, 2 * (WS + 3));
    @(posedge clk); #1;
    cpu_ce_n = 1'b1; cpu_oe_n = 1'b1;

`ifdef MEMC_ROUND_ROBIN_EN
    // continuous contention: grants alternate D,C,D,C (1 = display)
    rr_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_addr = 16'h0040;
    disp_req = 1'b1; disp_addr = 16'h1234;
    repeat (2) begin
      cpu_q.push_back(16'hBEEF);
      disp_q.push_back(16'h00FF);
    end
    k = 0; ev = 0;
    while (ev < 4 && k < 80) begin
      @(negedge clk); k++;
      if (disp_ack || !cpu_stall) begin
        check("rr_grant_order", disp_ack, rr_exp[ev]);
        ev++;
      end
    end
    check("rr_events", ev, 4);
    @(posedge clk); #1;
    cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; disp_req = 1'b0;
`endif

    // reset in the middle of a write (ACCESS, cnt=1 is k=3)
    @(posedge clk); #1;
    cpu_ce_n = 1'b0; cpu_we_n = 1'b0; cpu_addr = 16'h0100; cpu_din = 16'h3333;
    repeat (3) @(negedge clk);
    check("abort_we_low_before", sram_we_n, 0);
    #1 rst = 1'b1;
    #1;
    check("abort_we_n", sram_we_n, 1);
    check("abort_ce_n", sram_ce_n, 1);
    check("abort_dq_oe", sram_dq_oe, 0);
    cpu_ce_n = 1'b1; cpu_we_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    saw_ack = 1'b0; saw_ce = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (disp_ack) saw_ack = 1'b1;
      if (!sram_ce_n) saw_ce = 1'b1;
    end
    check("abort_no_ack", saw_ack, 0);
    check("abort_idle", saw_ce, 0);
    cpu_xfer(1'b0, 1'b0, 16'h0040, 16'hBEEF);

    repeat (3) @(negedge clk);
    check("sb_cpu_drained", cpu_q.size(), 0);
    check("sb_disp_drained", disp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memc_arbiter.md
Name: memc_arbiter

Overview:
- SRAM memory controller downstream of the CPU core.
- Consumes the CPU's SRAM strobes, address and write data, and arbitrates a single asynchronous SRAM between the CPU port (port 0) and the display/glyph fetch port (port 1).
- Generates SRAM pin timing with programmable wait states.
- Returns read data and a stall/ack to each requester.

Parameters:
- DATAWIDTH, 16, width of data buses and SRAM data pins
- ADDRWIDTH, 16, width of SRAM address
- WAIT_STATES, 2, extra ACCESS cycles per transfer (legal 0..7)

Ports:
- clk  input  1  system clock
- rst  input  1  reset (see Behaviour)
- cpu_ce_n  input  1  CPU SRAM chip enable, active low
- cpu_oe_n  input  1  CPU read strobe, active low
- cpu_we_n  input  1  CPU write strobe, active low
- cpu_addr  input  ADDRWIDTH  CPU address
- cpu_din  input  DATAWIDTH  CPU write data
- cpu_dout  output  DATAWIDTH  read data to CPU
- cpu_stall  output  1  CPU must hold request and freeze PC
- disp_req  input  1  display read request, held until ack
- disp_addr  input  ADDRWIDTH  display read address
- disp_dout  output  DATAWIDTH  read data to display
- disp_ack  output  1  one-cycle pulse, disp_dout valid
- sram_addr  output  ADDRWIDTH  SRAM address pins
- sram_dq_in  input  DATAWIDTH  SRAM data pins (read)
- sram_dq_out  output  DATAWIDTH  SRAM data pins (write)
- sram_dq_oe  output  1  tristate enable for sram_dq_out
- sram_ce_n  output  1  SRAM chip enable, active low
- sram_oe_n  output  1  SRAM output enable, active low
- sram_we_n  output  1  SRAM write enable, active low

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - FSM=IDLE; cnt=0.
  - sram_ce_n, sram_oe_n and sram_we_n are all 1; sram_dq_oe=0.
  - sram_addr, sram_dq_out, cpu_dout and disp_dout are all 0; disp_ack=0.
  - Reset mid-access aborts immediately (strobes high asynchronously); no ack is issued.
- Request decode:
  - cpu_req = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n).
  - The op is a write if cpu_we_n=0; write wins if both strobes are low.
  - The display port is always a read.
- Arbitration: evaluated only in IDLE. Fixed priority, display over CPU (the display has a real-time deadline).
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
  - IDLE:
    - On any request, register grant, addr, op and write data.
    - sram_addr and sram_dq_out are driven from these registers.
    - cnt=0; go to ACCESS. No request: stay.
  - ACCESS:
    - sram_ce_n=0.
    - Read: sram_oe_n=0.
    - Write: sram_dq_oe=1; sram_we_n=0 while cnt<WAIT_STATES, 1 on the final ACCESS cycle (data hold).
    - Address and data stay stable throughout.
    - cnt increments each cycle. When cnt==WAIT_STATES:
      - For a read, capture sram_dq_in into the granted port's dout register.
      - Go to DONE.
    - Duration is WAIT_STATES+1 cycles.
  - DONE:
    - All strobes high; sram_dq_oe=0 (bus turnaround).
    - disp_ack=1 if grant=display.
    - cpu_ack (internal) =1 if grant=CPU.
    - Go to IDLE.
- cpu_stall is combinational: cpu_req & ~(state==DONE & grant==CPU). It is low when there is no request.
- Latency: a request sampled in IDLE at edge N gives ack/stall release in cycle N+WAIT_STATES+2. The dout register is valid from that cycle and holds until the next read for that port.
- Back-to-back: a request still asserted in IDLE after DONE starts a new transfer. The minimum period is WAIT_STATES+3 cycles.
- A CPU request changing address during stall is a protocol violation. The latched value is used.
- The display request must stay high until ack. Dropping it mid-access still completes the transfer, and the ack is issued.

Optional Feature:
- MEMC_ROUND_ROBIN_EN
  - Defined: when both ports request in IDLE, grant goes to the port not granted last (last_grant flop, reset = CPU, so the display wins the first tie).
  - Undefined: fixed display priority. The CPU can starve under continuous display requests.

Decomposition:
- Shared package/defines:
  - FSM state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
  - Grant encodings (GNT_CPU=1'b0, GNT_DISP=1'b1).
  - DATAWIDTH/ADDRWIDTH defaults.
- One natural sub-module, memc_arb_sel: combinational grant select plus last_grant flop (holds the round-robin logic).
- FSM, counter and SRAM pin registers stay in the top level.

Test Plan:
- Reset mid-write:
  - Stimulus: CPU write in ACCESS cnt=1, assert rst.
  - Required: sram_we_n=1, sram_ce_n=1 and sram_dq_oe=0 same cycle; FSM IDLE after release; no ack.
- CPU write then read, WAIT_STATES=2:
  - Stimulus: write 0xBEEF to 0x0040, then read 0x0040.
  - Required: sram_we_n low for exactly 2 cycles; cpu_stall high 3 cycles then low in DONE; read returns cpu_dout=0xBEEF.
- Display read:
  - Stimulus: disp_req with disp_addr=0x1234, SRAM model returns 0x00FF.
  - Required: disp_ack pulses exactly one cycle at N+4; disp_dout=0x00FF.
- Simultaneous requests, macro undefined:
  - Stimulus: CPU and display request same cycle.
  - Required: display served first; CPU stall lasts 2×(WAIT_STATES+3) cycles.
- Same with MEMC_ROUND_ROBIN_EN, both requesting continuously:
  - Required: grants alternate D,C,D,C; each CPU access completes.
- WAIT_STATES=0:
  - Stimulus: CPU read.
  - Required: ACCESS lasts 1 cycle; cpu_stall high 1 cycle; sram_oe_n low exactly 1 cycle.
